reset_seq: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 33 +++
 rtl/reset_seq_debounce.sv | 67 ++++++
 rtl/reset_seq.sv | 160 ++++++++++++++++
 tb/tb_reset_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: sequencer states, reset-cause
// codes and the cause-priority helper.
package reset_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // Cause-of-last-reset codes as reported on rst_cause
  localparam logic [2:0] CAUSE_POR = 3'd0;
  localparam logic [2:0] CAUSE_BTN = 3'd1;
  localparam logic [2:0] CAUSE_WD  = 3'd2;
  localparam logic [2:0] CAUSE_SW  = 3'd3;

  // Resolve simultaneous reset requests: button beats watchdog beats software.
  function automatic logic [2:0] pick_cause(input logic btn, input logic wd, input logic sw);
    logic [2:0] cause;
    if (btn) begin
      cause = CAUSE_BTN;
    end else if (wd) begin
      cause = CAUSE_WD;
    end else if (sw) begin
      cause = CAUSE_SW;
    end else begin
      cause = CAUSE_POR;
    end
    return cause;
  endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Button debouncer: two-flop synchronizer followed by a stability counter.
// The debounced level only follows the synchronized input once it has held
// the new value for DEBOUNCE_CYCLES consecutive cycles. A one-cycle 'fall'
// pulse marks each accepted high-to-low transition (a press for active-low
// buttons).
module reset_seq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Synchronizer shift and stability counting toward a level change
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      // Input agrees with accepted level (or bounced back): restart.
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      // Held the new value long enough: accept it.
      level_d = sync2_q;
      cnt_d   = '0;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debouncer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      level_q <= RESET_LEVEL;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer. Holds memory and system resets for HOLD_CYCLES after any
// reset event, releases the memory controller first, then releases the
// system once the memory controller reports ready (or after MEM_TIMEOUT
// cycles, flagging mem_err). Reset events are a debounced button press, a
// watchdog pulse or a software pulse; the cause of the last one is kept for
// software and survives everything except rst_n.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MEM_TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_rst_n,
  input  logic       wd_trig,
  input  logic       sw_rst,
  input  logic       mem_ready,
  output logic       mem_rst_n,
  output logic       rst_out_n,
  output logic [2:0] rst_cause,
  output logic       mem_err
);

  localparam int unsigned       HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned       TO_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

  state_e            state_q,     state_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  logic [2:0]        cause_q,     cause_d;
  logic              mem_err_q,   mem_err_d;
  logic              mem_rst_n_q, mem_rst_n_d;
  logic              rst_out_n_q, rst_out_n_d;
  logic              rdy_sync1_q, rdy_sync1_d;
  logic              rdy_sync2_q, rdy_sync2_d;

  logic btn_level;
  logic btn_press;
  logic event_s;

  reset_seq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_rst_n),
    .level (btn_level),
    .fall  (btn_press)
  );

  assign event_s = btn_press | wd_trig | sw_rst;

  // mem_ready synchronizer, held clear while the memory controller is in reset
  always_comb begin
    if (!mem_rst_n_q) begin
      rdy_sync1_d = 1'b0;
      rdy_sync2_d = 1'b0;
    end else begin
      rdy_sync1_d = mem_ready;
      rdy_sync2_d = rdy_sync1_q;
    end
  end

  // Sequencer next state, counters, cause/error bookkeeping and output levels
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    cause_d    = cause_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_HOLD: begin
        // Requests are ignored here; a held button freezes the hold count.
        to_cnt_d = '0;
        if (!btn_level) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q >= HOLD_LAST) begin
          state_d    = ST_MEM_WAIT;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_MEM_WAIT: begin
        if (event_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          to_cnt_d   = '0;
          cause_d    = pick_cause(btn_press, wd_trig, sw_rst);
        end else if (rdy_sync2_q) begin
          state_d   = ST_RUN;
          to_cnt_d  = '0;
          mem_err_d = 1'b0;
        end else if (to_cnt_q >= TO_LAST) begin
          state_d   = ST_RUN;
          to_cnt_d  = '0;
          mem_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end
      ST_RUN: begin
        if (event_s) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          to_cnt_d   = '0;
          cause_d    = pick_cause(btn_press, wd_trig, sw_rst);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        to_cnt_d   = '0;
      end
    endcase
    // Outputs are registered copies of the next-state decode.
    mem_rst_n_d = (state_d != ST_HOLD);
    rst_out_n_d = (state_d == ST_RUN);
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      cause_q     <= CAUSE_POR;
      mem_err_q   <= 1'b0;
      mem_rst_n_q <= 1'b0;
      rst_out_n_q <= 1'b0;
      rdy_sync1_q <= 1'b0;
      rdy_sync2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cause_q     <= cause_d;
      mem_err_q   <= mem_err_d;
      mem_rst_n_q <= mem_rst_n_d;
      rst_out_n_q <= rst_out_n_d;
      rdy_sync1_q <= rdy_sync1_d;
      rdy_sync2_q <= rdy_sync2_d;
    end
  end

  assign mem_rst_n = mem_rst_n_q;
  assign rst_out_n = rst_out_n_q;
  assign rst_cause = cause_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with short parameters (HOLD 16, DEBOUNCE 8,
// MEM_TIMEOUT 100). A vector table covers power-up, software/timeout and
// simultaneous-request cases; hand-written sequences cover button bounce,
// extended hold and an asynchronous rst_n pulse during MEM_WAIT.
module tb_reset_seq;

  logic       clk;
  logic       rst_n;
  logic       btn_rst_n;
  logic       wd_trig;
  logic       sw_rst;
  logic       mem_ready;
  logic       mem_rst_n;
  logic       rst_out_n;
  logic [2:0] rst_cause;
  logic       mem_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst_n;
    logic       btn;
    logic       wd;
    logic       sw;
    logic       mr;
    int         ticks;
    logic       e_mem;
    logic       e_out;
    logic [2:0] e_cause;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  reset_seq #(
    .HOLD_CYCLES     (16),
    .DEBOUNCE_CYCLES (8),
    .MEM_TIMEOUT     (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_rst_n (btn_rst_n),
    .wd_trig   (wd_trig),
    .sw_rst    (sw_rst),
    .mem_ready (mem_ready),
    .mem_rst_n (mem_rst_n),
    .rst_out_n (rst_out_n),
    .rst_cause (rst_cause),
    .mem_err   (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic b, input logic w, input logic s,
                              input logic m, input int t, input logic em, input logic eo,
                              input logic [2:0] ec, input logic ee);
    vec_t v;
    v.rst_n = r; v.btn = b; v.wd = w; v.sw = s; v.mr = m; v.ticks = t;
    v.e_mem = em; v.e_out = eo; v.e_cause = ec; v.e_err = ee;
    return v;
  endfunction

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic em, input logic eo,
                       input logic [2:0] ec, input logic ee);
    checks++;
    if (mem_rst_n !== em) begin
      failures++;
      $display("FAIL %s mem_rst_n got=%b exp=%b", tag, mem_rst_n, em);
    end
    checks++;
    if (rst_out_n !== eo) begin
      failures++;
      $display("FAIL %s rst_out_n got=%b exp=%b", tag, rst_out_n, eo);
    end
    checks++;
    if (rst_cause !== ec) begin
      failures++;
      $display("FAIL %s rst_cause got=%0d exp=%0d", tag, rst_cause, ec);
    end
    checks++;
    if (mem_err !== ee) begin
      failures++;
      $display("FAIL %s mem_err got=%b exp=%b", tag, mem_err, ee);
    end
  endtask

  initial begin
    // Power-up: first edge with rst_n high is edge 1.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 15, 1'b0, 1'b0, 3'd0, 1'b0)); // edge 15
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b0, 3'd0, 1'b0)); // edge 16
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  4, 1'b1, 1'b0, 3'd0, 1'b0)); // edge 20
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b0, 3'd0, 1'b0)); // edge 22
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 3'd0, 1'b0)); // edge 23
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b1, 3'd0, 1'b0));
    // Software reset with memory never ready -> timeout release.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 99, 1'b1, 1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 3'd3, 1'b1));
    // Simultaneous watchdog + software -> watchdog; software in HOLD ignored.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b0, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b0, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 14, 1'b0, 1'b0, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b0, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  2, 1'b1, 1'b0, 3'd2, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 3'd2, 1'b0));

    rst_n     = 1'b0;
    btn_rst_n = 1'b1;
    wd_trig   = 1'b0;
    sw_rst    = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("por_async", 1'b0, 1'b0, 3'd0, 1'b0);
    tick(5);
    check("por_held", 1'b0, 1'b0, 3'd0, 1'b0);

    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst_n;
      btn_rst_n = vecs[i].btn;
      wd_trig   = vecs[i].wd;
      sw_rst    = vecs[i].sw;
      mem_ready = vecs[i].mr;
      tick(vecs[i].ticks);
      check($sformatf("vec%0d", i), vecs[i].e_mem, vecs[i].e_out, vecs[i].e_cause, vecs[i].e_err);
    end
    wd_trig = 1'b0;
    sw_rst  = 1'b0;

    // Short button bounces never reach the debounce threshold.
    for (int k = 0; k < 4; k++) begin
      btn_rst_n = 1'b0;
      tick(3);
      btn_rst_n = 1'b1;
      tick(3);
      check($sformatf("bounce%0d", k), 1'b1, 1'b1, 3'd2, 1'b0);
    end
    tick(4);

    // Held press: resets fall DEBOUNCE+3 edges after the press.
    btn_rst_n = 1'b0;
    tick(10);
    check("btn_pre", 1'b1, 1'b1, 3'd2, 1'b0);
    tick(1);
    check("btn_fall", 1'b0, 1'b0, 3'd1, 1'b0);
    tick(9);
    check("btn_held", 1'b0, 1'b0, 3'd1, 1'b0);
    // Release: debounce 10 edges, then full 16-edge hold.
    btn_rst_n = 1'b1;
    tick(25);
    check("btn_ext_hold", 1'b0, 1'b0, 3'd1, 1'b0);
    tick(1);
    check("btn_mem_rel", 1'b1, 1'b0, 3'd1, 1'b0);
    tick(2);
    check("btn_wait", 1'b1, 1'b0, 3'd1, 1'b0);
    tick(1);
    check("btn_run", 1'b1, 1'b1, 3'd1, 1'b0);

    // Build up cause=3, mem_err=1, then pulse rst_n during MEM_WAIT.
    mem_ready = 1'b0;
    sw_rst    = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check("sw2_hold", 1'b0, 1'b0, 3'd3, 1'b0);
    tick(116);
    check("sw2_timeout", 1'b1, 1'b1, 3'd3, 1'b1);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(21);
    check("sw3_memwait", 1'b1, 1'b0, 3'd3, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstn_async", 1'b0, 1'b0, 3'd0, 1'b0);
    tick(2);
    check("rstn_held", 1'b0, 1'b0, 3'd0, 1'b0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    tick(15);
    check("rstn_hold15", 1'b0, 1'b0, 3'd0, 1'b0);
    tick(1);
    check("rstn_mem_rel", 1'b1, 1'b0, 3'd0, 1'b0);
    tick(3);
    check("rstn_run", 1'b1, 1'b1, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
